// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the sequential BCD display ALU:
//   opcode encodings (OP_ADD..OP_ILL), screen select codes (SCR_RES/SCR_A/SCR_B/SCR_ILL),
//   FSM state encoding (ST_IDLE/ST_CONV/ST_DONE) and a constant power-of-ten helper
//   used for the elaboration-time digit-count check.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_ILL = 3'b111
  } opcode_e;

  localparam logic [1:0] SCR_RES = 2'b00;
  localparam logic [1:0] SCR_A   = 2'b01;
  localparam logic [1:0] SCR_B   = 2'b10;
  localparam logic [1:0] SCR_ILL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CONV = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // 10**n as a 64-bit constant, evaluated at elaboration time only
  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/alu_bcd_seq_bcd_dabble.sv
// bcd_dabble
//   Sequential double-dabble binary-to-BCD converter, one input bit per cycle.
//   A start pulse loads 'value' and clears the accumulator; the following WIDTH
//   cycles each perform "add 3 to every digit >= 5, then shift in the next MSB".
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     start        load a new value (ignored semantics while busy are "restart")
//     value        WIDTH-bit unsigned value to convert
//     busy         conversion in progress
//     done         high during the final conversion cycle
//     bcd          conversion result; equals the finished BCD value while done=1
module bcd_dabble
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [4*DIGITS-1:0] acc;
  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] acc_next;
  logic [WIDTH-1:0]    shreg;
  logic [CNT_W-1:0]    cnt;

  // One dabble step: digit correction followed by a left shift that pulls in
  // the current MSB of the shift register.
  always_comb begin
    adj = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
    end
    acc_next = {adj[4*DIGITS-2:0], shreg[WIDTH-1]};
  end

  // The result is exposed combinationally so the caller can capture it on the
  // same edge that finishes the conversion, without an extra latency cycle.
  assign done = busy && (cnt == CNT_W'(WIDTH - 1));
  assign bcd  = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      shreg <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      acc   <= '0;
      shreg <= value;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      acc   <= acc_next;
      shreg <= {shreg[WIDTH-2:0], 1'b0};
      cnt   <= cnt + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_bcd_seq.sv
// alu_bcd_seq
//   Handshaked display ALU: accepts one operation, computes a WIDTH-bit result and
//   flags, then converts the screen-selected value to DIGITS BCD digits with the
//   bcd_dabble sub-module (1 bit/cycle). Response is held until out_ready.
//   Optional feature macro: ALU_SIGNED_BCD_EN -- when defined, an ADD/SUB result
//   with MSB set shown on screen 00 is converted as its two's-complement magnitude
//   and 'negative' is raised. When undefined, conversion is unsigned and negative=0.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid/in_ready     request handshake
//     opcode, screen        operation and display select
//     a, b, carry_in        operands and carry/borrow in
//     out_valid/out_ready   response handshake
//     result, carry_out, overflow, bcd, negative, error   registered response
module alu_bcd_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            opcode,
  input  logic [1:0]            screen,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic                  carry_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      result,
  output logic                  carry_out,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  negative,
  output logic                  error
);

  localparam int MSB = WIDTH - 1;
  localparam longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1;

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("alu_bcd_seq: WIDTH must be at least 2");
    end
    if (pow10(DIGITS) <= MAX_VAL) begin : g_bad_digits
      $error("alu_bcd_seq: DIGITS too small to represent 2**WIDTH-1");
    end
  endgenerate

  state_e              state;
  logic [WIDTH-1:0]    alu_res;
  logic [WIDTH:0]      sum_ext;
  logic                alu_c;
  logic                alu_v;
  logic                op_err;
  logic                req_err;
  logic [WIDTH-1:0]    sel_val;
  logic [WIDTH-1:0]    conv_val;
  logic                accept;
  logic                dab_start;
  logic                dab_busy;
  logic                dab_done;
  logic                conv_last;
  logic [4*DIGITS-1:0] dab_bcd;

  // ALU datapath. Carry and signed overflow come from a WIDTH+1 bit sum/difference;
  // for SUB the extra bit is the borrow.
  always_comb begin
    alu_res = '0;
    sum_ext = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    op_err  = 1'b0;
    case (opcode_e'(opcode))
      OP_ADD: begin
        sum_ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      OP_SUB: begin
        sum_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, carry_in};
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      OP_SHL: begin
        alu_res = {a[WIDTH-2:0], 1'b0};
        alu_c   = a[MSB];
      end
      OP_ILL:  op_err = 1'b1;
      default: op_err = 1'b1;
    endcase
  end

  // Screen selection feeding the converter; an illegal screen is folded into
  // the same error path as an illegal opcode.
  always_comb begin
    case (screen)
      SCR_A:   sel_val = a;
      SCR_B:   sel_val = b;
      default: sel_val = alu_res;
    endcase
  end

  assign req_err = op_err || (screen == SCR_ILL);

`ifdef ALU_SIGNED_BCD_EN
  logic neg_now;

  // Only an arithmetic result on the result screen is treated as signed.
  assign neg_now  = (screen == SCR_RES) && alu_res[MSB] &&
                    ((opcode_e'(opcode) == OP_ADD) || (opcode_e'(opcode) == OP_SUB));
  assign conv_val = neg_now ? (-alu_res) : sel_val;
`else
  assign conv_val = sel_val;
  assign negative = 1'b0;
`endif

  assign accept    = in_valid && in_ready;
  assign dab_start = accept && !req_err;
  assign conv_last = dab_busy && dab_done;

  bcd_dabble #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_dabble (
    .clk   (clk),
    .rst_n (rst_n),
    .start (dab_start),
    .value (conv_val),
    .busy  (dab_busy),
    .done  (dab_done),
    .bcd   (dab_bcd)
  );

  // Control FSM with registered handshake and response outputs. Errors skip the
  // conversion entirely and present the all-F digit pattern straight away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      bcd       <= '0;
      error     <= 1'b0;
`ifdef ALU_SIGNED_BCD_EN
      negative  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (req_err) begin
              result    <= '0;
              carry_out <= 1'b0;
              overflow  <= 1'b0;
              bcd       <= {DIGITS{4'hF}};
              error     <= 1'b1;
`ifdef ALU_SIGNED_BCD_EN
              negative  <= 1'b0;
`endif
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else begin
              result    <= alu_res;
              carry_out <= alu_c;
              overflow  <= alu_v;
              error     <= 1'b0;
`ifdef ALU_SIGNED_BCD_EN
              negative  <= neg_now;
`endif
              state     <= ST_CONV;
            end
          end
        end
        ST_CONV: begin
          if (conv_last) begin
            bcd       <= dab_bcd;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bcd_seq.sv
// tb_alu_bcd_seq
//   Directed testbench for alu_bcd_seq with WIDTH=8, DIGITS=3. Each scenario task
//   drives its own requests and compares the registered response against
//   hand-computed values. Honours ALU_SIGNED_BCD_EN for the signed-display cases.
module tb_alu_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  opcode;
  logic [1:0]  screen;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  result;
  logic        carry_out;
  logic        overflow;
  logic [11:0] bcd;
  logic        negative;
  logic        error;

  int total;
  int bad;

  alu_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .screen    (screen),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .bcd       (bcd),
    .negative  (negative),
    .error     (error)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Present one request and hold it until accepted (bounded), then drop in_valid.
  task automatic send_req(input logic [2:0] op, input logic [1:0] scr,
                          input logic [7:0] va, input logic [7:0] vb, input logic cin);
    int waitc;
    waitc = 0;
    while (!in_ready && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    opcode   = op;
    screen   = scr;
    a        = va;
    b        = vb;
    carry_in = cin;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accepting edge until out_valid; -1 means it never came.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic release_resp();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({in_ready, out_valid, result, carry_out, overflow, bcd, negative, error} !==
        {1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL reset_state: got rdy=%b vld=%b res=%0d c=%b v=%b bcd=%h neg=%b err=%b, want rdy=1 vld=0 all zero",
               in_ready, out_valid, result, carry_out, overflow, bcd, negative, error);
    end
  endtask

  task automatic test_add_carry();
    int lat;
    send_req(3'b000, 2'b00, 8'd200, 8'd100, 1'b0);
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL add_busy_ready: got %b want 0", in_ready);
    end
    wait_valid(lat);
    total++;
    if (lat !== 8) begin
      bad++; $display("[TB] FAIL add_latency: got %0d want 8", lat);
    end
    total++;
    if ({result, carry_out, overflow, error} !== {8'd44, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("[TB] FAIL add_carry_res: got res=%0d c=%b v=%b err=%b want 44 1 0 0",
                      result, carry_out, overflow, error);
    end
    total++;
    if (bcd !== 12'h044) begin
      bad++; $display("[TB] FAIL add_carry_bcd: got %h want 044", bcd);
    end
    release_resp();
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("[TB] FAIL add_release: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_add_overflow();
    int lat;
    logic [11:0] exp_bcd;
    logic        exp_neg;
`ifdef ALU_SIGNED_BCD_EN
    exp_bcd = 12'h056;
    exp_neg = 1'b1;
`else
    exp_bcd = 12'h200;
    exp_neg = 1'b0;
`endif
    send_req(3'b000, 2'b00, 8'd100, 8'd100, 1'b0);
    wait_valid(lat);
    total++;
    if ({result, carry_out, overflow} !== {8'd200, 1'b0, 1'b1}) begin
      bad++; $display("[TB] FAIL add_ovf_res: got res=%0d c=%b v=%b want 200 0 1",
                      result, carry_out, overflow);
    end
    total++;
    if ({bcd, negative} !== {exp_bcd, exp_neg}) begin
      bad++; $display("[TB] FAIL add_ovf_bcd: got bcd=%h neg=%b want %h %b", bcd, negative, exp_bcd, exp_neg);
    end
    release_resp();
  endtask

  task automatic test_sub_borrow();
    int lat;
    logic [11:0] exp_bcd;
    logic        exp_neg;
`ifdef ALU_SIGNED_BCD_EN
    exp_bcd = 12'h005;
    exp_neg = 1'b1;
`else
    exp_bcd = 12'h251;
    exp_neg = 1'b0;
`endif
    send_req(3'b001, 2'b00, 8'd5, 8'd10, 1'b0);
    wait_valid(lat);
    total++;
    if ({result, carry_out, overflow} !== {8'd251, 1'b1, 1'b0}) begin
      bad++; $display("[TB] FAIL sub_res: got res=%0d c=%b v=%b want 251 1 0", result, carry_out, overflow);
    end
    total++;
    if ({bcd, negative} !== {exp_bcd, exp_neg}) begin
      bad++; $display("[TB] FAIL sub_bcd: got bcd=%h neg=%b want %h %b", bcd, negative, exp_bcd, exp_neg);
    end
    release_resp();
  endtask

  task automatic test_illegal();
    int lat;
    // Illegal opcode: response is presented right after the accepting edge.
    send_req(3'b111, 2'b00, 8'd12, 8'd34, 1'b1);
    wait_valid(lat);
    total++;
    if (lat !== 0) begin
      bad++; $display("[TB] FAIL ill_op_latency: got %0d want 0", lat);
    end
    total++;
    if ({error, result, carry_out, overflow, bcd} !== {1'b1, 8'd0, 1'b0, 1'b0, 12'hFFF}) begin
      bad++; $display("[TB] FAIL ill_op: got err=%b res=%0d c=%b v=%b bcd=%h want 1 0 0 0 fff",
                      error, result, carry_out, overflow, bcd);
    end
    release_resp();
    // Illegal screen with an otherwise valid ADD.
    send_req(3'b000, 2'b11, 8'd200, 8'd100, 1'b0);
    wait_valid(lat);
    total++;
    if ({error, result, carry_out, bcd} !== {1'b1, 8'd0, 1'b0, 12'hFFF}) begin
      bad++; $display("[TB] FAIL ill_scr: got err=%b res=%0d c=%b bcd=%h want 1 0 0 fff",
                      error, result, carry_out, bcd);
    end
    release_resp();
  endtask

  task automatic test_screens();
    int lat;
    send_req(3'b010, 2'b01, 8'd255, 8'd15, 1'b0);
    wait_valid(lat);
    total++;
    if ({bcd, result, error, negative} !== {12'h255, 8'd15, 1'b0, 1'b0}) begin
      bad++; $display("[TB] FAIL scr_a_and: got bcd=%h res=%0d err=%b neg=%b want 255 15 0 0",
                      bcd, result, error, negative);
    end
    release_resp();
    // Screen B shows b while flags still come from SHL.
    send_req(3'b110, 2'b10, 8'h81, 8'd42, 1'b0);
    wait_valid(lat);
    total++;
    if ({bcd, result, carry_out, overflow} !== {12'h042, 8'h02, 1'b1, 1'b0}) begin
      bad++; $display("[TB] FAIL scr_b_shl: got bcd=%h res=%h c=%b v=%b want 042 02 1 0",
                      bcd, result, carry_out, overflow);
    end
    release_resp();
  endtask

  task automatic test_back_to_back();
    int lat;
    send_req(3'b000, 2'b00, 8'd1, 8'd2, 1'b0);
    wait_valid(lat);
    // A competing request is held on the inputs while the consumer stalls.
    opcode   = 3'b011;
    screen   = 2'b00;
    a        = 8'd50;
    b        = 8'd60;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if ({out_valid, in_ready, result, bcd} !== {1'b1, 1'b0, 8'd3, 12'h003}) begin
        bad++; $display("[TB] FAIL stall_hold_%0d: got vld=%b rdy=%b res=%0d bcd=%h want 1 0 3 003",
                        i, out_valid, in_ready, result, bcd);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    total++;
    if ({out_valid, in_ready, result, bcd} !== {1'b0, 1'b1, 8'd3, 12'h003}) begin
      bad++; $display("[TB] FAIL stall_release: got vld=%b rdy=%b res=%0d bcd=%h want 0 1 3 003",
                      out_valid, in_ready, result, bcd);
    end
    @(posedge clk); #1;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("[TB] FAIL stall_no_capture: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_conv();
    int lat;
    send_req(3'b000, 2'b00, 8'd9, 8'd9, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, result, carry_out, overflow, bcd, negative, error} !==
        {1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0}) begin
      bad++; $display("[TB] FAIL mid_conv_reset: got rdy=%b vld=%b res=%0d bcd=%h err=%b want 1 0 0 000 0",
                      in_ready, out_valid, result, bcd, error);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    send_req(3'b000, 2'b00, 8'd3, 8'd4, 1'b0);
    wait_valid(lat);
    total++;
    if (lat !== 8) begin
      bad++; $display("[TB] FAIL post_reset_latency: got %0d want 8", lat);
    end
    total++;
    if ({result, bcd} !== {8'd7, 12'h007}) begin
      bad++; $display("[TB] FAIL post_reset_res: got res=%0d bcd=%h want 7 007", result, bcd);
    end
    release_resp();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opcode    = 3'b000;
    screen    = 2'b00;
    a         = 8'd0;
    b         = 8'd0;
    carry_in  = 1'b0;
    #12;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_add_carry();
    test_add_overflow();
    test_sub_borrow();
    test_illegal();
    test_screens();
    test_back_to_back();
    test_reset_mid_conv();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
